// File: rtl/decoder_pkg.sv
// Shared constants for the Thumb/ARM fetch aligner.
// BL halfword patterns, halfword width and the aligner FSM states.
package decoder_pkg;

  localparam int HW_W = 16;

  localparam logic [4:0] BL_PREFIX = 5'b11110;
  localparam logic [4:0] BL_SUFFIX = 5'b11111;

  typedef enum logic {
    ST_STREAM,
    ST_SKIP_LO
  } state_e;

endpackage

// File: rtl/hw_ring.sv
// Circular halfword ring: 2-wide write (or upper-only), 2-wide read.
// Pointers carry a wrap bit so count = wptr - rptr covers full/empty.
module hw_ring
  import decoder_pkg::*;
#(
  parameter int DEPTH_HW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic                        wr_hi_only,
  input  logic [31:0]                 wr_data,
  input  logic                        rd_en,
  input  logic                        rd_two,
  output logic [$clog2(DEPTH_HW):0]   count,
  output logic [HW_W-1:0]             rd_lo,
  output logic [HW_W-1:0]             rd_hi
);

  localparam int AW = $clog2(DEPTH_HW);

  logic [HW_W-1:0] mem [DEPTH_HW];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [AW-1:0]   wa0;
  logic [AW-1:0]   wa1;
  logic [AW-1:0]   ra0;
  logic [AW-1:0]   ra1;

  assign wa0 = wptr[AW-1:0];
  assign wa1 = wa0 + AW'(1);
  assign ra0 = rptr[AW-1:0];
  assign ra1 = ra0 + AW'(1);

  // Upper-only write lands at wptr, lower halfword is dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_hi_only) begin
        mem[wa0] <= wr_data[31:16];
      end else begin
        mem[wa0] <= wr_data[15:0];
        mem[wa1] <= wr_data[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + (wr_hi_only ? (AW+1)'(1) : (AW+1)'(2));
      if (rd_en)
        rptr <= rptr + (rd_two ? (AW+1)'(2) : (AW+1)'(1));
    end
  end

  assign count = wptr - rptr;
  assign rd_lo = mem[ra0];
  assign rd_hi = mem[ra1];

endmodule

// File: rtl/thumb_fetch_align.sv
// Fetch aligner: splits fetched words into ARM words or Thumb halfwords.
// Define THUMB_BL_FUSE_EN to fuse Thumb BL prefix/suffix pairs.
module thumb_fetch_align
  import decoder_pkg::*;
#(
  parameter int DEPTH_HW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        flush_addr1,
  input  logic        thumb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_code,
  output logic        out_len32,
  output logic        out_bl_pair
);

  localparam int AW = $clog2(DEPTH_HW);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH_HW);

  state_e          state;
  logic [AW:0]     count;
  logic [AW:0]     free;
  logic [HW_W-1:0] head;
  logic [HW_W-1:0] next;
  logic            skip;
  logic            push;
  logic            pop;
  logic            pop_two;
  logic            fuse_pair;
  logic            pre_stall;

  hw_ring #(.DEPTH_HW(DEPTH_HW)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .wr_en      (push),
    .wr_hi_only (skip),
    .wr_data    (in_word),
    .rd_en      (pop),
    .rd_two     (pop_two),
    .count      (count),
    .rd_lo      (head),
    .rd_hi      (next)
  );

  assign skip     = (state == ST_SKIP_LO);
  assign free     = CAP - count;
  assign in_ready = !flush && (skip ? (free >= ONE) : (free >= TWO));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready && !flush;

`ifdef THUMB_BL_FUSE_EN
  assign fuse_pair = thumb && (head[15:11] == BL_PREFIX) &&
                     (count >= TWO) && (next[15:11] == BL_SUFFIX);
  // A lone prefix waits for its partner before anything is emitted.
  assign pre_stall = thumb && (head[15:11] == BL_PREFIX) &&
                     (count == ONE);
`else
  assign fuse_pair = 1'b0;
  assign pre_stall = 1'b0;
`endif

  always_comb begin
    out_valid   = 1'b0;
    out_code    = '0;
    out_len32   = 1'b0;
    out_bl_pair = 1'b0;
    pop_two     = 1'b0;
    unique case (1'b1)
      !thumb: begin
        if (count >= TWO) begin
          out_valid = 1'b1;
          out_code  = {next, head};
          out_len32 = 1'b1;
          pop_two   = 1'b1;
        end
      end
      fuse_pair: begin
        out_valid   = 1'b1;
        out_code    = {head, next};
        out_len32   = 1'b1;
        out_bl_pair = 1'b1;
        pop_two     = 1'b1;
      end
      pre_stall: begin
        out_valid = 1'b0;
      end
      default: begin
        if (count != '0) begin
          out_valid = 1'b1;
          out_code  = {16'h0, head};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_STREAM;
    else if (flush)
      state <= (flush_addr1 && thumb) ? ST_SKIP_LO : ST_STREAM;
    else if (skip && push)
      state <= ST_STREAM;
  end

endmodule

// File: tb/tb_thumb_fetch_align.sv
// Bench for thumb_fetch_align: directed table plus random vs queue model.
// Follows THUMB_BL_FUSE_EN to select fused or unfused expectations.
module tb_thumb_fetch_align;

  localparam int DEPTH = 8;
`ifdef THUMB_BL_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, flush_addr1, thumb;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        out_len32, out_bl_pair;
  logic [31:0] in_word, out_code;

  always #5 clk = ~clk;

  thumb_fetch_align #(.DEPTH_HW(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_addr1 (flush_addr1),
    .thumb       (thumb),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_len32   (out_len32),
    .out_bl_pair (out_bl_pair)
  );

  typedef struct {
    logic        r, f, a1, th, iv;
    logic [31:0] w;
    logic        ordy;
    logic        ev;
    logic [31:0] ec;
    logic        el, eb, er;
  } vec_t;

  vec_t        tbl[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] q[$];
  bit          mskip = 1'b0;

  task automatic add(logic r, logic f, logic a1, logic th, logic iv,
                     logic [31:0] w, logic ordy, logic ev,
                     logic [31:0] ec, logic el, logic eb, logic er);
    vec_t v;
    v.r = r; v.f = f; v.a1 = a1; v.th = th; v.iv = iv;
    v.w = w; v.ordy = ordy; v.ev = ev; v.ec = ec;
    v.el = el; v.eb = eb; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(logic r, logic f, logic a1, logic th, logic iv,
                       logic [31:0] w, logic ordy);
    @(negedge clk);
    rst = r; flush = f; flush_addr1 = a1; thumb = th;
    in_valid = iv; in_word = w; out_ready = ordy;
    #1;
  endtask

  function automatic logic [15:0] rhw();
    case ($urandom_range(0, 2))
      0:       return {5'b11110, 11'($urandom)};
      1:       return {5'b11111, 11'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference: queue of buffered halfwords, applied after the checks.
  task automatic model_step();
    logic        ev, el, eb, er, pre;
    logic [31:0] ec;
    int          np, n;
    n = q.size();
    ev = 0; ec = 0; el = 0; eb = 0; np = 0; pre = 0;
    er = !flush && ((DEPTH - n) >= (mskip ? 1 : 2));
    if (!thumb) begin
      if (n >= 2) begin
        ev = 1; ec = {q[1], q[0]}; el = 1; np = 2;
      end
    end else if (n >= 1) begin
      pre = (q[0][15:11] == 5'b11110);
      if (FUSE && pre && n >= 2 && q[1][15:11] == 5'b11111) begin
        ev = 1; ec = {q[0], q[1]}; el = 1; eb = 1; np = 2;
      end else if (!(FUSE && pre && n == 1)) begin
        ev = 1; ec = {16'h0, q[0]}; np = 1;
      end
    end
    chk("rnd_out_valid", 32'(out_valid), 32'(ev));
    chk("rnd_out_code", out_code, ec);
    chk("rnd_out_len32", 32'(out_len32), 32'(el));
    chk("rnd_out_bl_pair", 32'(out_bl_pair), 32'(eb));
    chk("rnd_in_ready", 32'(in_ready), 32'(er));
    if (rst) begin
      q.delete();
      mskip = 0;
    end else if (flush) begin
      q.delete();
      mskip = flush_addr1 && thumb;
    end else begin
      if (ev && out_ready)
        repeat (np) void'(q.pop_front());
      if (in_valid && er) begin
        if (!mskip) q.push_back(in_word[15:0]);
        q.push_back(in_word[31:16]);
        mskip = 0;
      end
    end
  endtask

  initial begin
    logic th_r;
    rst = 1; flush = 0; flush_addr1 = 0; thumb = 0;
    in_valid = 0; in_word = 0; out_ready = 0;
    repeat (3) @(posedge clk);

    add(0,0,0,0,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,1,0,0,0,32'h0,1,        0,32'h0,0,0,0);
    add(0,0,0,0,1,32'hE3A01005,1, 0,32'h0,0,0,1);
    add(0,0,0,0,1,32'hE0812002,1, 1,32'hE3A01005,1,0,1);
    add(0,0,0,0,0,32'h0,1,        1,32'hE0812002,1,0,1);
    add(0,0,0,0,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,1,0,1,0,32'h0,1,        0,32'h0,0,0,0);
    add(0,0,0,1,1,32'h1C482001,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'h2001,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'h1C48,0,0,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,1,1,1,0,32'h0,1,        0,32'h0,0,0,0);
    add(0,0,0,1,1,32'h46C02001,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'h46C0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,1,1,0,0,32'h0,0,        0,32'h0,0,0,0);
    add(0,0,0,0,1,32'h11111111,0, 0,32'h0,0,0,1);
    add(0,0,0,0,1,32'h22222222,0, 1,32'h11111111,1,0,1);
    add(0,0,0,0,1,32'h33333333,0, 1,32'h11111111,1,0,1);
    add(0,0,0,0,1,32'h44444444,0, 1,32'h11111111,1,0,1);
    add(0,0,0,0,1,32'h55555555,0, 1,32'h11111111,1,0,0);
    add(0,1,0,0,1,32'h66666666,1, 1,32'h11111111,1,0,0);
    add(0,0,0,0,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,0,0,0,1,32'hAAAA5555,0, 0,32'h0,0,0,1);
    add(0,0,0,0,1,32'hBBBB6666,0, 1,32'hAAAA5555,1,0,1);
    add(1,0,0,0,1,32'hCCCC7777,1, 1,32'hAAAA5555,1,0,1);
    add(0,0,0,0,0,32'h0,1,        0,32'h0,0,0,1);
`ifdef THUMB_BL_FUSE_EN
    add(0,1,0,1,0,32'h0,1,        0,32'h0,0,0,0);
    add(0,0,0,1,1,32'hF800F000,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'hF000F800,1,1,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,0,0,1,1,32'hF0002001,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'h2001,0,0,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
    add(0,0,0,1,1,32'h2002F800,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'hF000F800,1,1,1);
    add(0,0,0,1,0,32'h0,1,        1,32'h2002,0,0,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
`else
    add(0,1,0,1,0,32'h0,1,        0,32'h0,0,0,0);
    add(0,0,0,1,1,32'hF800F000,1, 0,32'h0,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'hF000,0,0,1);
    add(0,0,0,1,0,32'h0,1,        1,32'hF800,0,0,1);
    add(0,0,0,1,0,32'h0,1,        0,32'h0,0,0,1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].a1, tbl[i].th, tbl[i].iv,
            tbl[i].w, tbl[i].ordy);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_out_code", i), out_code, tbl[i].ec);
      chk($sformatf("tbl%0d_out_len32", i), 32'(out_len32), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_out_bl_pair", i), 32'(out_bl_pair),
          32'(tbl[i].eb));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].er));
    end

    drive(1, 0, 0, 1, 0, 32'h0, 0);
    q.delete();
    mskip = 0;
    th_r = 1;
    for (int c = 0; c < 3000; c++) begin
      logic r, f, a1;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 15) == 0);
      a1 = $urandom_range(0, 1);
      if (f) th_r = ($urandom_range(0, 3) != 0);
      drive(r, f, a1, th_r, ($urandom_range(0, 9) < 7),
            {rhw(), rhw()}, ($urandom_range(0, 9) < 6));
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
